// File: rtl/eco32f_cache_refill_pkg.sv
// Shared definitions for the cache refill engine: FSM state encoding,
// Wishbone cycle-type/burst-type constants and cache line geometry
// (32-byte lines, 8 words per line).
package eco32f_cache_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam int unsigned LINE_WORDS       = 8;
    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam logic [2:0]  LAST_WORD        = 3'(LINE_WORDS - 1);

    // Cycle type for the beat at word_cnt; classic cycles when bursts are off.
    function automatic logic [2:0] refill_cti(input logic burst, input logic [2:0] word_cnt);
        logic [2:0] cti;
        if (!burst) begin
            cti = CTI_CLASSIC;
        end else if (word_cnt == LAST_WORD) begin
            cti = CTI_END;
        end else begin
            cti = CTI_INCR;
        end
        return cti;
    endfunction

endpackage

// File: rtl/eco32f_cache_refill_if.sv
// Bundle of every non-clock signal of the refill engine.
//   Pipeline side : req, req_addr, miss, inv_req, inv_addr -> inv_ack
//   Status        : busy, refill_done, refill_err
//   Cache write   : write_addr, write_data, write_en, invalidate
//   Wishbone B3   : wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
//                   wbm_dat_i, wbm_ack_i, wbm_err_i
// master = the refill engine, slave = pipeline/cache/bus environment.
interface eco32f_cache_refill_if;

    logic        req;
    logic [31:0] req_addr;
    logic        miss;
    logic        inv_req;
    logic [31:0] inv_addr;
    logic        inv_ack;
    logic        busy;
    logic        refill_done;
    logic        refill_err;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write_en;
    logic        invalidate;
    logic [31:0] wbm_adr_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  req, req_addr, miss, inv_req, inv_addr,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output inv_ack, busy, refill_done, refill_err,
        output write_addr, write_data, write_en, invalidate,
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o
    );

    modport slave (
        output req, req_addr, miss, inv_req, inv_addr,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  inv_ack, busy, refill_done, refill_err,
        input  write_addr, write_data, write_en, invalidate,
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o
    );

endinterface

// File: rtl/eco32f_cache_refill.sv
// Cache refill engine. On a miss it fetches the 8-word line over Wishbone
// and streams each acked word into the cache write port; only the last word
// is written with the valid bit set, so a partial or aborted line stays
// invalid. Line-invalidate requests share the same write port while idle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - eco32f_cache_refill_if.master (pipeline, cache write, Wishbone)
// Parameter OPTION_BURST: 1 = incrementing burst CTI, 0 = classic cycles.
module eco32f_cache_refill
    import eco32f_cache_refill_pkg::*;
#(
    parameter bit OPTION_BURST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    eco32f_cache_refill_if.master        bus
);

    state_t                        state_q;
    logic [31:LINE_OFFSET_BITS]    line_addr_q;
    logic [2:0]                    word_cnt_q;
    logic                          cyc_q;
    logic                          refill_err_q;

    logic        in_refill_s;
    logic        err_s;
    logic        ack_s;
    logic        last_s;
    logic        inv_fire_s;
    logic        start_s;
    logic [31:0] bus_adr_s;
    logic        write_en_s;
    logic        invalidate_s;
    logic        inv_ack_s;
    logic [31:0] write_addr_s;
    logic [31:0] write_data_s;
    logic        unused_s;

    assign in_refill_s = (state_q == ST_REFILL);
    // A bus error wins over a simultaneous ack: that word is never written.
    assign err_s       = in_refill_s && bus.wbm_err_i;
    assign ack_s       = in_refill_s && bus.wbm_ack_i && !bus.wbm_err_i;
    assign last_s      = (word_cnt_q == LAST_WORD);
    // Invalidates are only taken in IDLE and take priority over a new miss.
    assign inv_fire_s  = (state_q == ST_IDLE) && bus.inv_req;
    assign start_s     = (state_q == ST_IDLE) && !bus.inv_req && bus.req && bus.miss;
    assign bus_adr_s   = {line_addr_q, word_cnt_q, 2'b00};
    assign unused_s    = ^bus.req_addr[LINE_OFFSET_BITS-1:0];

    // Refill FSM, line/word tracking and registered bus/status strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_addr_q  <= '0;
            word_cnt_q   <= 3'd0;
            cyc_q        <= 1'b0;
            refill_err_q <= 1'b0;
        end else begin
            refill_err_q <= err_s;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        line_addr_q <= bus.req_addr[31:LINE_OFFSET_BITS];
                        word_cnt_q  <= 3'd0;
                        cyc_q       <= 1'b1;
                        state_q     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (err_s) begin
                        cyc_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ack_s) begin
                        // Wraps 7->0 on the final beat, leaving the counter clean.
                        word_cnt_q <= word_cnt_q + 3'd1;
                        if (last_s) begin
                            cyc_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    cyc_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Cache write port: invalidate writes in IDLE, data writes straight from ack.
    always_comb begin
        write_en_s   = 1'b0;
        invalidate_s = 1'b0;
        inv_ack_s    = 1'b0;
        write_addr_s = 32'd0;
        write_data_s = 32'd0;
        if (inv_fire_s) begin
            write_en_s   = 1'b1;
            invalidate_s = 1'b1;
            inv_ack_s    = 1'b1;
            write_addr_s = bus.inv_addr;
        end else if (ack_s) begin
            write_en_s   = 1'b1;
            invalidate_s = !last_s;
            write_addr_s = bus_adr_s;
            write_data_s = bus.wbm_dat_i;
        end else begin
            write_en_s   = 1'b0;
        end
    end

    assign bus.write_en    = write_en_s;
    assign bus.invalidate  = invalidate_s;
    assign bus.inv_ack     = inv_ack_s;
    assign bus.write_addr  = write_addr_s;
    assign bus.write_data  = write_data_s;

    assign bus.busy        = (state_q == ST_REFILL) || (state_q == ST_DONE);
    assign bus.refill_done = (state_q == ST_DONE);
    assign bus.refill_err  = refill_err_q;

    assign bus.wbm_adr_o   = bus_adr_s;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_cti_o   = in_refill_s ? refill_cti(OPTION_BURST, word_cnt_q) : CTI_CLASSIC;
    assign bus.wbm_bte_o   = BTE_LINEAR;

endmodule
